// File: rtl/scalar_mask_gen_pkg.sv
// Shared definitions for the scalar functional units: opcodes, architectural widths,
// count saturation helper and the mask generator's stage-1 record.
package scalar_mask_gen_pkg;

  localparam int S_WIDTH     = 64;
  localparam int A_WIDTH     = 24;
  localparam int COUNT_WIDTH = 7;

  localparam logic [6:0] OP_POP        = 7'b0010110;
  localparam logic [6:0] OP_LZC        = 7'b0010111;
  localparam logic [6:0] OP_ONES_MASK  = 7'b0100010;
  localparam logic [6:0] OP_ZEROS_MASK = 7'b0100011;

  // Any count of 64 or more, including stray upper A bits, clamps to a full word.
  function automatic logic [COUNT_WIDTH-1:0] sat_count(input logic [A_WIDTH-1:0] ak);
    if (|ak[A_WIDTH-1:6]) return 7'd64;
    return ak[COUNT_WIDTH-1:0];
  endfunction

  typedef struct packed {
    logic       full;
    logic [2:0] b;
    logic [2:0] r;
    logic       op_zeros;
  } s1_t;

endpackage

// File: rtl/scalar_mask_gen_thermo8.sv
// Combinational 3-bit index to 8-bit MSB-first thermometer (r_i leading ones).
module thermo8 (
  input  logic [2:0] r_i,
  output logic [7:0] thermo_o
);

  assign thermo_o = ~(8'hFF >> r_i);

endmodule

// File: rtl/scalar_mask_gen.sv
// Scalar mask generator (042 ones mask / 043 zeros mask), 2-edge latency, one op per clock.
// Stage 1 captures the split saturated count, stage 2 assembles the 64-bit word.
module scalar_mask_gen
  import scalar_mask_gen_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [A_WIDTH-1:0]     i_ak,
  input  logic [6:0]             i_instr,
  input  logic                   i_valid,
  output logic [S_WIDTH-1:0]     o_result,
  output logic                   o_valid
);

  logic [COUNT_WIDTH-1:0] cnt;
  s1_t                    s1_d, s1_q;
  logic                   vld1_d, vld1_q;
  logic [S_WIDTH-1:0]     res_d, res_q;
  logic                   vld2_q;
  logic [7:0]             fill, part;

  always_comb begin
    cnt            = sat_count(i_ak);
    s1_d.full      = cnt[6];
    s1_d.b         = cnt[5:3];
    s1_d.r         = cnt[2:0];
    s1_d.op_zeros  = (i_instr == OP_ZEROS_MASK);
    vld1_d         = i_valid && ((i_instr == OP_ONES_MASK) || (i_instr == OP_ZEROS_MASK));
  end

  thermo8 u_fill (.r_i(s1_q.b), .thermo_o(fill));
  thermo8 u_part (.r_i(s1_q.r), .thermo_o(part));

  // fill[k] set means byte k lies entirely above the boundary byte (7-b).
  always_comb begin
    res_d = '0;
    for (int k = 0; k < 8; k++) begin
      if (fill[k]) begin
        res_d[8*k +: 8] = 8'hFF;
      end else if (3'(7 - k) == s1_q.b) begin
        res_d[8*k +: 8] = part;
      end
    end
    if (s1_q.full) res_d = '1;
    if (s1_q.op_zeros) res_d = ~res_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= '0;
      vld1_q <= 1'b0;
      res_q  <= '0;
      vld2_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      vld1_q <= vld1_d;
      vld2_q <= vld1_q;
      if (vld1_q) res_q <= res_d;
    end
  end

  assign o_result = res_q;
  assign o_valid  = vld2_q;

endmodule

// File: tb/tb_scalar_mask_gen.sv
// Directed bench for scalar_mask_gen: single ops, saturation, streaming with a bubble,
// async reset mid-flight and a leading-zero round trip over every count.
module tb_scalar_mask_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] i_ak = '0;
  logic [6:0]  i_instr = '0;
  logic        i_valid = 1'b0;
  logic [63:0] o_result;
  logic        o_valid;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] OP42 = 7'b0100010;
  localparam logic [6:0] OP43 = 7'b0100011;
  localparam logic [6:0] OP26 = 7'b0010110;

  scalar_mask_gen dut (
    .clk      (clk),
    .rst      (rst),
    .i_ak     (i_ak),
    .i_instr  (i_instr),
    .i_valid  (i_valid),
    .o_result (o_result),
    .o_valid  (o_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, confirm nothing after edge 1, result after edge 2, valid drops after edge 3.
  task automatic single(input string tag, input logic [6:0] op, input logic [23:0] ak,
                        input logic [63:0] exp);
    i_instr = op;
    i_ak    = ak;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check({tag, "_v1"}, {63'd0, o_valid}, 64'd0);
    tick();
    check({tag, "_v2"}, {63'd0, o_valid}, 64'd1);
    check({tag, "_res"}, o_result, exp);
    tick();
    check({tag, "_v3"}, {63'd0, o_valid}, 64'd0);
  endtask

  logic [6:0]  s_op [6];
  logic [23:0] s_ak [6];
  logic        s_v  [6];
  logic [63:0] s_r  [6];

  initial begin
    #1;
    check("rst_valid", {63'd0, o_valid}, 64'd0);
    check("rst_result", o_result, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    single("o42_0",  OP42, 24'd0,  64'h0000_0000_0000_0000);
    single("o42_1",  OP42, 24'd1,  64'h8000_0000_0000_0000);
    single("o42_12", OP42, 24'd12, 64'hFFF0_0000_0000_0000);
    single("o42_63", OP42, 24'd63, 64'hFFFF_FFFF_FFFF_FFFE);
    single("o43_0",  OP43, 24'd0,  64'hFFFF_FFFF_FFFF_FFFF);
    single("o43_12", OP43, 24'd12, 64'h000F_FFFF_FFFF_FFFF);
    single("o43_64", OP43, 24'd64, 64'h0000_0000_0000_0000);
    single("sat_100", OP42, 24'd100,     64'hFFFF_FFFF_FFFF_FFFF);
    single("sat_80",  OP42, 24'h000080,  64'hFFFF_FFFF_FFFF_FFFF);
    single("sat_ff",  OP43, 24'hFFFFFF,  64'h0000_0000_0000_0000);

    // Back-to-back stream; the 026 slot must show no valid and the prior result held.
    s_op[0] = OP42; s_ak[0] = 24'd3;  s_v[0] = 1'b1; s_r[0] = 64'hE000_0000_0000_0000;
    s_op[1] = OP43; s_ak[1] = 24'd8;  s_v[1] = 1'b1; s_r[1] = 64'h00FF_FFFF_FFFF_FFFF;
    s_op[2] = OP26; s_ak[2] = 24'd5;  s_v[2] = 1'b0; s_r[2] = 64'h00FF_FFFF_FFFF_FFFF;
    s_op[3] = OP42; s_ak[3] = 24'd64; s_v[3] = 1'b1; s_r[3] = 64'hFFFF_FFFF_FFFF_FFFF;
    s_op[4] = OP43; s_ak[4] = 24'd1;  s_v[4] = 1'b1; s_r[4] = 64'h7FFF_FFFF_FFFF_FFFF;
    s_op[5] = OP42; s_ak[5] = 24'd0;  s_v[5] = 1'b1; s_r[5] = 64'h0000_0000_0000_0000;
    for (int e = 0; e <= 6; e++) begin
      if (e < 6) begin
        i_instr = s_op[e];
        i_ak    = s_ak[e];
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      tick();
      if (e >= 1) begin
        check($sformatf("strm%0d_v", e - 1), {63'd0, o_valid}, {63'd0, s_v[e-1]});
        check($sformatf("strm%0d_res", e - 1), o_result, s_r[e-1]);
      end
    end
    tick();
    check("strm_end_v", {63'd0, o_valid}, 64'd0);

    // Async reset between the two edges of an in-flight op.
    single("pre_rst", OP42, 24'd7, 64'hFE00_0000_0000_0000);
    i_instr = OP42;
    i_ak    = 24'd5;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, o_valid}, 64'd0);
    check("arst_result", o_result, 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_idle%0d", i), {63'd0, o_valid}, 64'd0);
    end
    single("post_rst", OP42, 24'd5, 64'hF800_0000_0000_0000);

    // Round trip: leading zeros of each 043 result give back the count.
    for (int c = 0; c <= 64; c++) begin
      int lz;
      logic [63:0] exp43;
      exp43 = (c == 64) ? 64'd0 : ({64{1'b1}} >> c);
      single($sformatf("rt%0d", c), OP43, 24'(c), exp43);
      lz = 0;
      while (lz < 64 && o_result[63 - lz] == 1'b0) lz++;
      check($sformatf("rt%0d_lz", c), 64'(lz), 64'(c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
